bf_tape_ram: RTL and testbench



---
 rtl/bf_tape_ram.sv | 125 ++++++++++++
 tb/tb_bf_tape_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_tape_ram.sv
// Data tape for the bf core: self-clearing RAM with a host preload/dump side-port.
// Core and host reads have 1-cycle latency; host_ready is low while clearing, on core access or clr.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module bf_tape_ram #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write,
    output logic [DATA_WIDTH-1:0] read,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  host_valid,
    input  logic                  host_wen,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  idle_ok;
    logic                  core_rd;
    logic                  host_acc;
    logic                  host_rd;

    // A clr request in IDLE blocks every access in that cycle, core included.
    assign idle_ok    = (state == IDLE) && !clr;
    assign host_ready = idle_ok && !en;
    assign host_acc   = host_valid && host_ready;
    assign host_rd    = host_acc && !host_wen;
    assign core_rd    = idle_ok && en && !wen;
    assign busy       = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == '1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep, the core and the host.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (idle_ok && en && wen) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = write;
        end else if (host_acc && host_wen) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read        <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_rd;
            if (core_rd) begin
                read <= mem[addr];
            end
            if (host_rd) begin
                host_rdata <= mem[host_addr];
            end
        end
    end

endmodule

// File: tb/tb_bf_tape_ram.sv
// Directed bench for bf_tape_ram with a 16-cell tape.
module tb_bf_tape_ram;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, wen, clr, busy;
    logic [3:0] addr, host_addr;
    logic [7:0] write, read, host_wdata, host_rdata;
    logic       host_valid, host_wen, host_ready, host_rvalid;

    int total = 0;
    int bad   = 0;

    bf_tape_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wen(wen), .addr(addr),
        .write(write), .read(read), .clr(clr), .busy(busy),
        .host_valid(host_valid), .host_wen(host_wen), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 0; wen = 0; addr = 0; write = 0; clr = 0;
        host_valid = 0; host_wen = 0; host_addr = 0; host_wdata = 0;
        #1;
        total++;
        if (busy !== 1'b1 || host_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl busy=%b ready=%b need busy=1 ready=0", busy, host_ready);
        end
        total++;
        if (read !== 8'h00 || host_rdata !== 8'h00 || host_rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_data read=%h rdata=%h rvalid=%b need 00 00 0", read, host_rdata, host_rvalid);
        end
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 200) begin n++; step(); end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL reset_busy_len got=%0d need=16", n);
        end
        for (int a = 0; a < 16; a++) begin
            en = 1; wen = 0; addr = 4'(a);
            step();
            total++;
            if (read !== 8'h00) begin
                bad++; $display("FAIL reset_zero addr=%0d got=%h need=00", a, read);
            end
        end
        en = 0;
    endtask

    task automatic test_core_write_read();
        en = 1; wen = 1; addr = 4'd3; write = 8'h5A;
        step();
        total++;
        if (read !== 8'h00) begin
            bad++; $display("FAIL core_write_hold got=%h need=00", read);
        end
        wen = 0;
        step();
        total++;
        if (read !== 8'h5A) begin
            bad++; $display("FAIL core_read got=%h need=5a", read);
        end
        en = 0;
    endtask

    task automatic test_host_priority();
        int early;
        en = 1; wen = 0; addr = 4'd0;
        host_valid = 1; host_wen = 0; host_addr = 4'd3;
        early = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (host_ready !== 1'b0) early++;
            step();
            if (host_rvalid !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL host_prio_blocked violations=%0d need=0", early);
        end
        en = 0;
        #1;
        total++;
        if (host_ready !== 1'b1) begin
            bad++; $display("FAIL host_prio_accept ready=%b need=1", host_ready);
        end
        step();
        host_valid = 0;
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h5A) begin
            bad++; $display("FAIL host_prio_data rvalid=%b rdata=%h need 1 5a", host_rvalid, host_rdata);
        end
        step();
        total++;
        if (host_rvalid !== 1'b0) begin
            bad++; $display("FAIL host_prio_pulse rvalid=%b need=0", host_rvalid);
        end
    endtask

    task automatic test_host_preload();
        int nr;
        nr = 0;
        for (int i = 0; i < 16; i++) begin
            host_valid = 1; host_wen = 1; host_addr = 4'(i); host_wdata = 8'(i + 1);
            #1;
            if (host_ready !== 1'b1) nr++;
            step();
        end
        host_valid = 0;
        total++;
        if (nr != 0) begin
            bad++; $display("FAIL preload_ready stalls=%0d need=0", nr);
        end
        en = 1; wen = 0; addr = 4'd15;
        step();
        total++;
        if (read !== 8'h10) begin
            bad++; $display("FAIL preload_read15 got=%h need=10", read);
        end
        addr = 4'd0;
        step();
        total++;
        if (read !== 8'h01) begin
            bad++; $display("FAIL preload_read0 got=%h need=01", read);
        end
        en = 0;
    endtask

    task automatic test_back_to_back();
        en = 0; host_valid = 1; host_wen = 0; host_addr = 4'd4;
        step();
        host_addr = 4'd5;
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h05) begin
            bad++; $display("FAIL b2b_first rvalid=%b rdata=%h need 1 05", host_rvalid, host_rdata);
        end
        step();
        host_valid = 0;
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h06) begin
            bad++; $display("FAIL b2b_second rvalid=%b rdata=%h need 1 06", host_rvalid, host_rdata);
        end
        en = 1; wen = 1; addr = 4'd7; write = 8'hA7;
        step();
        en = 0; host_valid = 1; host_wen = 0; host_addr = 4'd7;
        step();
        host_valid = 0;
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'hA7) begin
            bad++; $display("FAIL core_then_host rvalid=%b rdata=%h need 1 a7", host_rvalid, host_rdata);
        end
        step();
    endtask

    task automatic test_clear();
        int n, rdy, nz;
        en = 0; host_valid = 1; host_wen = 1; host_addr = 4'd9; host_wdata = 8'h99;
        clr = 1;
        #1;
        total++;
        if (host_ready !== 1'b0) begin
            bad++; $display("FAIL clr_ready ready=%b need=0", host_ready);
        end
        step();
        clr = 0;
        en = 1; wen = 1; addr = 4'd2; write = 8'hEE;
        n = 0; rdy = 0;
        while (busy && n < 200) begin
            n++;
            clr = (n == 5);
            #1;
            if (host_ready !== 1'b0) rdy++;
            step();
        end
        clr = 0; en = 0; wen = 0; host_valid = 0;
        total++;
        if (n != 21) begin
            bad++; $display("FAIL clr_busy_len got=%0d need=21", n);
        end
        total++;
        if (rdy != 0) begin
            bad++; $display("FAIL clr_host_blocked violations=%0d need=0", rdy);
        end
        nz = 0;
        for (int a = 0; a < 16; a++) begin
            en = 1; addr = 4'(a);
            step();
            if (read !== 8'h00) nz++;
        end
        en = 0;
        total++;
        if (nz != 0) begin
            bad++; $display("FAIL clr_zeroed nonzero_cells=%0d need=0", nz);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        en = 1; wen = 1; addr = 4'd11; write = 8'h3C;
        step();
        en = 0;
        clr = 1;
        step();
        clr = 0;
        repeat (8) step();
        rst_n = 0;
        #1;
        total++;
        if (busy !== 1'b1 || read !== 8'h00) begin
            bad++; $display("FAIL rst_mid_async busy=%b read=%h need 1 00", busy, read);
        end
        repeat (2) step();
        rst_n = 1;
        n = 0;
        while (busy && n < 200) begin n++; step(); end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL rst_mid_busy_len got=%0d need=16", n);
        end
        en = 1; wen = 0; addr = 4'd11;
        step();
        en = 0;
        total++;
        if (read !== 8'h00) begin
            bad++; $display("FAIL rst_mid_zero got=%h need=00", read);
        end
    endtask

    initial begin
        test_reset();
        test_core_write_read();
        test_host_priority();
        test_host_preload();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
